// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic_div_16by8 divider.
// Holds:
//   - the operand widths,
//   - the iteration count,
//   - the FSM state encoding,
//   - the quotient value reported for a zero divisor.
package vedic_pkg;

    localparam int DW    = 16;            // dividend / quotient width
    localparam int VW    = 8;             // divisor / remainder width
    localparam int ITERS = DW;            // one quotient bit per BUSY cycle
    localparam int CW    = $clog2(ITERS); // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/vedic_div_step.sv
// One restoring-division step. This block is purely combinational.
//
// Operation:
//   - The partial remainder is shifted left by one place.
//   - The next dividend bit is shifted in at the bottom.
//   - The divisor is subtracted when it fits.
//
// Ports:
//   r_i    [VW:0]    partial remainder before the step
//   d_i    [VW-1:0]  divisor
//   bit_i            dividend bit shifted in at the LSB
//   r_o    [VW:0]    partial remainder after the step
//   q_o              quotient bit produced by this step
module vedic_div_step
    import vedic_pkg::*;
(
    input  logic [VW:0]   r_i,
    input  logic [VW-1:0] d_i,
    input  logic          bit_i,
    output logic [VW:0]   r_o,
    output logic          q_o
);

    logic [VW:0] shifted;
    logic        ge;

    always_comb begin
        shifted = {r_i[VW-1:0], bit_i};
        // The bit shifted out of r_i is part of the true shifted value.
        // When that bit is set, the value is at least 2^(VW+1), so it is
        // certainly >= D. The modular subtraction below still returns the
        // exact remainder in that case.
        ge = r_i[VW] | (shifted >= {1'b0, d_i});
        if (ge) begin
            r_o = shifted - {1'b0, d_i};
            q_o = 1'b1;
        end else begin
            r_o = shifted;
            q_o = 1'b0;
        end
    end

endmodule

// File: rtl/vedic_div_16by8.sv
// Sequential restoring divider that inverts the vedic_8bit multiplier.
//
// Operation:
//   - A 16-bit dividend is divided by an 8-bit divisor.
//   - One quotient bit is produced per clock.
//   - A start/busy/done handshake controls each division.
//
// Optional self-check: define VEDIC_DIV_CHECK_EN to instantiate vedic_8bit.
//   - The multiplier re-multiplies each result.
//   - check_err is raised (sticky until rst) when q*d + r != dividend.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request; accepted only in IDLE or DONE
//   dividend [15:0] numerator, captured on the accepting edge
//   divisor  [7:0]  denominator, captured on the accepting edge
//   busy            high while dividing
//   done            one-cycle pulse when the results are valid
//   quotient [15:0] result; held until the next result is loaded
//   remainder [7:0] result; held until the next result is loaded
//   div_by_zero     set with the results when the divisor was 0
//   check_err       self-check flag (0 when the check is compiled out)
module vedic_div_16by8
    import vedic_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          check_err
);

    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [VW:0]   r_q;
    logic [VW:0]   r_d;
    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [VW-1:0] d_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] rem_q;
    logic          dz_q;
    logic          qbit;

    vedic_div_step u_step (
        .r_i   (r_q),
        .d_i   (d_q),
        .bit_i (q_q[DW-1]),
        .r_o   (r_d),
        .q_o   (qbit)
    );

    // Q shifts out dividend bits at the top and collects quotient bits
    // at the bottom.
    assign q_d = {q_q[DW-2:0], qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        count_q <= '0;
                        if (divisor == '0) begin
                            state_q <= DONE;
                            quot_q  <= DIV0_QUOT;
                            rem_q   <= dividend[VW-1:0];
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            dz_q    <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q <= DONE;
                        quot_q  <= q_d;
                        rem_q   <= r_d[VW-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

`ifdef VEDIC_DIV_CHECK_EN
    logic [DW-1:0] dvd_q;
    logic [DW-1:0] prod;
    logic          chk_q;

    vedic_8bit u_mul (
        .a (quot_q[VW-1:0]),
        .b (d_q),
        .p (prod)
    );

    // Only quotients that fit in 8 bits can be re-multiplied by the
    // 8x8 multiplier. Zero-divisor results are excluded by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else begin
            if ((state_q == IDLE || state_q == DONE) && start) begin
                dvd_q <= dividend;
            end
            if (state_q == DONE && quot_q[DW-1:VW] == '0 && !dz_q &&
                (prod + {{(DW-VW){1'b0}}, rem_q}) != dvd_q) begin
                chk_q <= 1'b1;
            end
        end
    end

    assign check_err = chk_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_div_16by8.sv
module tb_vedic_div_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        check_err;

    int errors = 0;
    int checks = 0;

    vedic_div_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .check_err   (check_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model.
    // Phases:
    //   0 = idle
    //   1 = dividing
    //   2 = result pulse
    // Results come from plain / and %.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [15:0] m_quot = '0;
    logic [15:0] m_pq = '0;
    logic [7:0]  m_rem = '0;
    logic [7:0]  m_pr = '0;
    logic        m_dz = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_quot  <= '0;
            m_rem   <= '0;
            m_dz    <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_phase != 1 && start) begin
            if (divisor == 8'd0) begin
                m_phase <= 2;
                m_quot  <= 16'hFFFF;
                m_rem   <= dividend[7:0];
                m_dz    <= 1'b1;
            end else begin
                m_phase <= 1;
                m_left  <= 16;
                m_pq    <= dividend / {8'd0, divisor};
                m_pr    <= 8'(dividend % {8'd0, divisor});
                m_dz    <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (m_left == 1) begin
                m_phase <= 2;
                m_quot  <= m_pq;
                m_rem   <= m_pr;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_phase == 2) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", busy, (m_phase == 1));
            chk("model_done", done, (m_phase == 2));
            chk("model_quot", quotient, m_quot);
            chk("model_rem", remainder, m_rem);
            chk("model_dz", div_by_zero, m_dz);
            chk("model_chk", check_err, 0);
        end
    end

    task automatic launch_now(input logic [15:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        launch_now(a, b);
    endtask

    // Counts edges from the accepting edge, which is counted as edge 1.
    task automatic wait_done(output int edges);
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    int e;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        rst = 1'b0;

        // 65025 / 255
        launch(16'd65025, 8'd255);
        chk("t1_busy", busy, 1);
        wait_done(e);
        chk("t1_lat", e, 17);
        chk("t1_quot", quotient, 255);
        chk("t1_rem", remainder, 0);
        chk("t1_dz", div_by_zero, 0);

        // 100 / 7, then hold through idle cycles
        launch(16'd100, 8'd7);
        wait_done(e);
        chk("t2_lat", e, 17);
        chk("t2_quot", quotient, 14);
        chk("t2_rem", remainder, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_quot", quotient, 14);
            chk("t2_hold_rem", remainder, 2);
        end

        // divide by zero
        launch(16'd65535, 8'd0);
        wait_done(e);
        chk("t3_lat", e, 1);
        chk("t3_quot", quotient, 16'hFFFF);
        chk("t3_rem", remainder, 255);
        chk("t3_dz", div_by_zero, 1);

        // 65535 / 1, then back-to-back 49 / 7 started during DONE
        launch(16'd65535, 8'd1);
        wait_done(e);
        chk("t4_lat", e, 17);
        chk("t4_quot", quotient, 65535);
        chk("t4_rem", remainder, 0);
        chk("t4_dz", div_by_zero, 0);
        launch_now(16'd49, 8'd7);
        chk("t4_b2b_busy", busy, 1);
        chk("t4_b2b_done", done, 0);
        wait_done(e);
        chk("t4_b2b_lat", e, 17);
        chk("t4_b2b_quot", quotient, 7);
        chk("t4_b2b_rem", remainder, 0);

        // start while busy is ignored
        launch(16'd225, 8'd15);
        repeat (4) @(negedge clk);
        launch_now(16'd9, 8'd3);
        wait_done(e);
        chk("t5_lat", e, 12);
        chk("t5_quot", quotient, 15);
        chk("t5_rem", remainder, 0);

        // reset mid-division
        launch(16'd200, 8'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_quot", quotient, 0);
        chk("t6_rem", remainder, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
        end
        launch(16'd9, 8'd3);
        wait_done(e);
        chk("t6_lat", e, 17);
        chk("t6_quot2", quotient, 3);
        chk("t6_rem2", remainder, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vedic_div_16by8.md
Name: vedic_div_16by8

Overview:
- Sequential restoring divider that undoes `vedic_8bit`: it takes a 16-bit product and an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder.
- It is the inverse-path block for the multiplier datapath. Its main uses are recovering an operand from a known product and an 8-bit factor, and self-checking the multiplier in system tests.
- It produces one quotient bit per clock and uses a start/busy/done handshake.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width.
- ITERS, DW, number of iteration cycles. Fixed equal to DW; not independently overridable.

Ports:
- clk  input  1  system clock. All state is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Sampled only when the block is in IDLE or DONE.
- dividend  input  DW  numerator. Captured on the edge where start is accepted.
- divisor  input  VW  denominator. Captured on the edge where start is accepted.
- busy  output  1  high while in BUSY.
- done  output  1  one-cycle pulse: quotient and remainder are valid.
- quotient  output  DW  result. Held until the next accepted start.
- remainder  output  VW  result. Held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0. Held alongside the results.
- check_err  output  1  self-check flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state←IDLE, count←0.
  - busy, done, quotient, remainder, div_by_zero and check_err all go to 0.
  - Reset takes priority over every other event, including mid-BUSY. An in-flight division is discarded and done is never issued for it.
- States: IDLE, BUSY, DONE. Encoding comes from the package.
- IDLE or DONE with start=1:
  - Capture dividend into the shift register Q and divisor into D. Clear the partial remainder R (VW+1 bits). Set count←0.
  - If D==0: go to DONE. quotient←16'hFFFF, remainder←dividend[7:0], div_by_zero←1.
  - Otherwise: go to BUSY and clear div_by_zero.
- DONE with start=0: go to IDLE. done is high only during the single cycle spent in DONE.
- BUSY, each edge:
  - {R,Q} ← {R,Q}<<1.
  - If the shifted R ≥ D: R←R−D and Q[0]←1. Otherwise Q[0]←0.
  - count←count+1.
- BUSY exit: on the edge where count==ITERS−1, go to DONE and load quotient←Q and remainder←R[VW−1:0].
- Latency:
  - Nonzero divisor: done is high in the cycle after the 16th BUSY edge, i.e. 17 edges after the accepting edge.
  - Zero divisor: done is high after 1 edge.
- Throughput: back-to-back operation is allowed. start sampled high during DONE is accepted, so DONE→BUSY directly and done does not re-pulse in the following cycle.
- start while BUSY is ignored; the operands are not re-captured.
- Arithmetic is unsigned throughout. R is one bit wider than VW so the compare cannot overflow. Post-condition: quotient·divisor + remainder == dividend, and remainder < divisor.
- quotient and remainder keep their values through IDLE and BUSY until the next result is loaded.
- busy = (state==BUSY), driven combinationally from the state register.

Optional Feature:
- Macro: VEDIC_DIV_CHECK_EN.
- Defined:
  - Instantiate `vedic_8bit` on (quotient[7:0], divisor).
  - In DONE, check_err←1 if quotient[15:8]==0, div_by_zero==0, and product+remainder ≠ dividend.
  - check_err is sticky until rst.
- Undefined: check_err is tied to 0 and no multiplier is instantiated.

Decomposition:
- Package `vedic_pkg` holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - widths DW=16 and VW=8;
  - the divide-by-zero quotient constant 16'hFFFF.
- Sub-module `vedic_div_step` (combinational): inputs R, D and incoming bit; outputs next R and quotient bit. The top level holds the FSM, counter and registers.

Test Plan:
- dividend=65025, divisor=255, start for 1 cycle → busy for 16 cycles; done exactly 17 edges after acceptance; quotient=255, remainder=0, div_by_zero=0.
- dividend=100, divisor=7 → quotient=14, remainder=2; outputs held unchanged for 5 idle cycles after done.
- dividend=65535, divisor=0 → done 1 edge after start; quotient=16'hFFFF, remainder=255, div_by_zero=1.
- dividend=65535, divisor=1 → quotient=65535, remainder=0. Then start with dividend=49, divisor=7 during DONE → second done 17 edges later with quotient=7, remainder=0.
- Start 225/15, then pulse start with 9/3 at BUSY cycle 5 → second request ignored; quotient=15, remainder=0.
- rst at BUSY cycle 8 → next cycle busy=0, done=0, quotient=0, remainder=0. No done is issued afterward, and a fresh 9/3 yields quotient=3, remainder=0.
